// File: rtl/clamp_sched_s6.sv
// Round-robin scheduler feeding a shared two-stage round-and-clamp datapath (32-bit signed -> 6-bit signed).
// Optional saturation counter output sat_cnt is enabled by defining CLAMP_SCHED_SAT_CNT_EN.
module clamp_sched_s6 #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_REQ-1:0]      req_valid,
   input  logic [32*N_REQ-1:0]   req_data,
   output logic [N_REQ-1:0]      req_ready,
   input  logic [4:0]            cfg_shift,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [5:0]            out_data,
   output logic [ID_W-1:0]       out_id,
   output logic                  out_sat
`ifdef CLAMP_SCHED_SAT_CNT_EN
   ,
   output logic [15:0]           sat_cnt
`endif
);

   logic            s1_valid_q, s1_valid_d;
   logic [31:0]     s1_x_q, s1_x_d;
   logic [4:0]      s1_shift_q, s1_shift_d;
   logic [ID_W-1:0] s1_id_q, s1_id_d;
   logic            s2_valid_q, s2_valid_d;
   logic [5:0]      s2_data_q, s2_data_d;
   logic [ID_W-1:0] s2_id_q, s2_id_d;
   logic            s2_sat_q, s2_sat_d;
   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

   logic            s2_free, s1_adv, s1_free, in_fire;
   logic            gnt_found;
   logic [ID_W-1:0] gnt_id, cand;
   logic [ID_W:0]   cand_sum, nxt_sum;
   logic [31:0]     sel_x;
   logic signed [32:0] x_ext, rnd, r;
   logic [5:0]      clamp_data;
   logic            clamp_sat;

   assign s2_free = !s2_valid_q || out_ready;
   assign s1_adv  = s1_valid_q && s2_free;
   assign s1_free = !s1_valid_q || s1_adv;
   assign in_fire = !rst && gnt_found && s1_free;

   // First valid lane found when scanning upward from rr_ptr, wrapping at N_REQ
   always_comb begin
      gnt_found = 1'b0;
      gnt_id    = '0;
      cand_sum  = '0;
      cand      = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
         if (cand_sum >= (ID_W+1)'(N_REQ)) cand_sum = cand_sum - (ID_W+1)'(N_REQ);
         cand = cand_sum[ID_W-1:0];
         if (!gnt_found && req_valid[cand]) begin
            gnt_found = 1'b1;
            gnt_id    = cand;
         end
      end
   end

   always_comb begin
      sel_x     = '0;
      req_ready = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt_id == ID_W'(i)) sel_x = req_data[32*i +: 32];
         req_ready[i] = in_fire && (gnt_id == ID_W'(i));
      end
   end

   // 33-bit arithmetic keeps x + 2^(shift-1) from overflowing at the positive limit
   always_comb begin
      x_ext = {s1_x_q[31], s1_x_q};
      rnd   = '0;
      r     = x_ext;
      if (s1_shift_q != 5'd0) begin
         rnd = 33'sd1 <<< (s1_shift_q - 5'd1);
         r   = (x_ext + rnd) >>> s1_shift_q;
      end
      if (r < -33'sd32) begin
         clamp_data = 6'b100000;
         clamp_sat  = 1'b1;
      end else if (r > 33'sd31) begin
         clamp_data = 6'b011111;
         clamp_sat  = 1'b1;
      end else begin
         clamp_data = r[5:0];
         clamp_sat  = 1'b0;
      end
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_x_d     = s1_x_q;
      s1_shift_d = s1_shift_q;
      s1_id_d    = s1_id_q;
      s2_valid_d = s2_valid_q;
      s2_data_d  = s2_data_q;
      s2_id_d    = s2_id_q;
      s2_sat_d   = s2_sat_q;
      rr_ptr_d   = rr_ptr_q;
      nxt_sum    = {1'b0, gnt_id} + (ID_W+1)'(1);

      if (s2_free) s2_valid_d = s1_valid_q;
      if (s1_adv) begin
         s2_data_d = clamp_data;
         s2_id_d   = s1_id_q;
         s2_sat_d  = clamp_sat;
      end
      if (s1_adv) s1_valid_d = 1'b0;
      if (in_fire) begin
         s1_valid_d = 1'b1;
         s1_x_d     = sel_x;
         s1_shift_d = cfg_shift;
         s1_id_d    = gnt_id;
         rr_ptr_d   = (nxt_sum == (ID_W+1)'(N_REQ)) ? '0 : nxt_sum[ID_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_x_q     <= '0;
         s1_shift_q <= '0;
         s1_id_q    <= '0;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         s2_id_q    <= '0;
         s2_sat_q   <= 1'b0;
         rr_ptr_q   <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_x_q     <= s1_x_d;
         s1_shift_q <= s1_shift_d;
         s1_id_q    <= s1_id_d;
         s2_valid_q <= s2_valid_d;
         s2_data_q  <= s2_data_d;
         s2_id_q    <= s2_id_d;
         s2_sat_q   <= s2_sat_d;
         rr_ptr_q   <= rr_ptr_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign out_data  = s2_data_q;
   assign out_id    = s2_id_q;
   assign out_sat   = s2_sat_q;

`ifdef CLAMP_SCHED_SAT_CNT_EN
   logic [15:0] sat_cnt_q, sat_cnt_d;

   always_comb begin
      sat_cnt_d = sat_cnt_q;
      if (s2_valid_q && out_ready && s2_sat_q && (sat_cnt_q != 16'hFFFF))
         sat_cnt_d = sat_cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) sat_cnt_q <= '0;
      else     sat_cnt_q <= sat_cnt_d;
   end

   assign sat_cnt = sat_cnt_q;
`endif

endmodule

// File: tb/tb_clamp_sched_s6.sv
// Directed, table-driven bench for clamp_sched_s6; sat_cnt checks are built when CLAMP_SCHED_SAT_CNT_EN is defined.
module tb_clamp_sched_s6;
   localparam int N_REQ = 4;
   localparam int ID_W  = 2;

   logic                clk;
   logic                rst;
   logic [N_REQ-1:0]    req_valid;
   logic [32*N_REQ-1:0] req_data;
   logic [N_REQ-1:0]    req_ready;
   logic [4:0]          cfg_shift;
   logic                out_valid;
   logic                out_ready;
   logic [5:0]          out_data;
   logic [ID_W-1:0]     out_id;
   logic                out_sat;
`ifdef CLAMP_SCHED_SAT_CNT_EN
   logic [15:0]         sat_cnt;
`endif

   int checks = 0;
   int errors = 0;

   clamp_sched_s6 #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .cfg_shift (cfg_shift),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_id    (out_id),
      .out_sat   (out_sat)
`ifdef CLAMP_SCHED_SAT_CNT_EN
      ,
      .sat_cnt   (sat_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [31:0] x;
      logic [4:0]  sh;
      logic [5:0]  exp_d;
      logic        exp_s;
   } vec_t;

   vec_t tbl[13];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic send_chk(input int lane, input logic [31:0] x, input logic [4:0] sh,
                           input logic [5:0] ed, input logic es, input string nm);
      int cyc;
      @(negedge clk);
      req_valid = '0;
      req_valid[lane] = 1'b1;
      req_data[32*lane +: 32] = x;
      cfg_shift = sh;
      #1;
      cyc = 0;
      while (!req_ready[lane] && cyc < 20) begin
         @(negedge clk); #1; cyc++;
      end
      if (!req_ready[lane]) begin
         chk({nm, "_ready_timeout"}, 32'(req_ready), 32'(1 << lane));
         req_valid = '0;
         return;
      end
      @(posedge clk); #1;
      req_valid = '0;
      req_data  = '1;
      cfg_shift = 5'd7;
      cyc = 0;
      while (!out_valid && cyc < 10) begin
         @(negedge clk); cyc++;
      end
      chk({nm, "_latency"}, 32'(cyc), 32'd2);
      chk({nm, "_valid"},   32'(out_valid), 32'd1);
      chk({nm, "_data"},    32'(out_data), 32'(ed));
      chk({nm, "_id"},      32'(out_id), 32'(lane));
      chk({nm, "_sat"},     32'(out_sat), 32'(es));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      req_valid = '0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      tbl[0]  = '{32'd100,          5'd2,  6'd25,      1'b0};
      tbl[1]  = '{32'(-1000),       5'd0,  6'(-32),    1'b1};
      tbl[2]  = '{32'h7FFFFFFF,     5'd31, 6'd1,       1'b0};
      tbl[3]  = '{32'd31,           5'd0,  6'd31,      1'b0};
      tbl[4]  = '{32'd32,           5'd0,  6'd31,      1'b1};
      tbl[5]  = '{32'(-32),         5'd0,  6'(-32),    1'b0};
      tbl[6]  = '{32'(-33),         5'd0,  6'(-32),    1'b1};
      tbl[7]  = '{32'(-5),          5'd1,  6'(-2),     1'b0};
      tbl[8]  = '{32'd5,            5'd1,  6'd3,       1'b0};
      tbl[9]  = '{32'hFFFFFFFF,     5'd31, 6'd0,       1'b0};
      tbl[10] = '{32'h80000000,     5'd31, 6'(-1),     1'b0};
      tbl[11] = '{32'd1000,         5'd4,  6'd31,      1'b1};
      tbl[12] = '{32'(-7),          5'd2,  6'(-2),     1'b0};

      rst = 1'b1;
      req_valid = '0;
      req_data = '0;
      cfg_shift = '0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data",  32'(out_data), 32'd0);
      chk("rst_out_id",    32'(out_id), 32'd0);
      chk("rst_out_sat",   32'(out_sat), 32'd0);
      req_valid = '1;
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      req_valid = '0;
      rst = 1'b0;

      for (int i = 0; i < 13; i++)
         send_chk(i % N_REQ, tbl[i].x, tbl[i].sh, tbl[i].exp_d, tbl[i].exp_s, $sformatf("vec%0d", i));

      // All lanes valid right after reset: grants 0,1,2,3,0,1 with no gaps
      begin
         int cyc;
         do_reset();
         for (int i = 0; i < N_REQ; i++) req_data[32*i +: 32] = 32'(i + 1);
         cfg_shift = 5'd0;
         req_valid = '1;
         cyc = 0;
         while (!out_valid && cyc < 10) begin
            @(negedge clk); cyc++;
         end
         chk("rr_first_latency", 32'(cyc), 32'd2);
         for (int k = 0; k < 6; k++) begin
            chk($sformatf("rr_valid%0d", k), 32'(out_valid), 32'd1);
            chk($sformatf("rr_id%0d", k),    32'(out_id), 32'(k % N_REQ));
            chk($sformatf("rr_data%0d", k),  32'(out_data), 32'((k % N_REQ) + 1));
            @(negedge clk);
         end
         req_valid = '0;
         repeat (4) @(negedge clk);
      end

      // Back-pressure for 5 cycles, then drain in order
      begin
         do_reset();
         out_ready = 1'b0;
         req_valid = '1;
         for (int n = 1; n <= 5; n++) begin
            @(negedge clk); #1;
            if (n >= 2) begin
               chk($sformatf("bp_valid%0d", n), 32'(out_valid), 32'd1);
               chk($sformatf("bp_data%0d", n),  32'(out_data), 32'd1);
               chk($sformatf("bp_id%0d", n),    32'(out_id), 32'd0);
               chk($sformatf("bp_ready%0d", n), 32'(req_ready), 32'd0);
            end
         end
         out_ready = 1'b1;
         for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain_valid%0d", k), 32'(out_valid), 32'd1);
            chk($sformatf("drain_id%0d", k),    32'(out_id), 32'(k));
            chk($sformatf("drain_data%0d", k),  32'(out_data), 32'(k + 1));
            @(negedge clk);
         end
         req_valid = '0;
         repeat (4) @(negedge clk);
      end

      // Reset with both stages full; rr_ptr was 2 and must restart at 0
      begin
         int cyc;
         do_reset();
         out_ready = 1'b0;
         req_valid = '1;
         repeat (3) @(negedge clk);
         rst = 1'b1;
         req_valid = '0;
         @(negedge clk);
         chk("mid_rst_valid", 32'(out_valid), 32'd0);
         rst = 1'b0;
         out_ready = 1'b1;
         for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk($sformatf("stale%0d", n), 32'(out_valid), 32'd0);
         end
         req_data[32*1 +: 32] = 32'd7;
         req_data[32*2 +: 32] = 32'd9;
         req_valid = 4'b0110;
         cyc = 0;
         while (!out_valid && cyc < 10) begin
            @(negedge clk); cyc++;
         end
         chk("post_rst_id",   32'(out_id), 32'd1);
         chk("post_rst_data", 32'(out_data), 32'd7);
         req_valid = '0;
         repeat (4) @(negedge clk);
      end

`ifdef CLAMP_SCHED_SAT_CNT_EN
      begin
         do_reset();
         chk("satcnt_rst", 32'(sat_cnt), 32'd0);
         send_chk(0, 32'(-1000), 5'd0, 6'(-32), 1'b1, "sc0");
         send_chk(1, 32'd5,      5'd1, 6'd3,    1'b0, "sc1");
         send_chk(2, 32'd500,    5'd0, 6'd31,   1'b1, "sc2");
         send_chk(3, 32'd100,    5'd2, 6'd25,   1'b0, "sc3");
         send_chk(0, 32'd64,     5'd1, 6'd31,   1'b1, "sc4");
         @(negedge clk);
         chk("satcnt_three", 32'(sat_cnt), 32'd3);
         for (int i = 0; i < N_REQ; i++) req_data[32*i +: 32] = 32'(-1000);
         cfg_shift = 5'd0;
         req_valid = '1;
         repeat (65540) @(negedge clk);
         chk("satcnt_hold", 32'(sat_cnt), 32'hFFFF);
         req_valid = '0;
         repeat (4) @(negedge clk);
         chk("satcnt_hold2", 32'(sat_cnt), 32'hFFFF);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
